// File: rtl/bip_datapath.sv
// -----------------------------------------------------------------------------
// bip_datapath
//   Accumulator datapath of a basic instruction processor: sign-extended
//   immediate, combinational-read data RAM, add/subtract ALU and an
//   accumulator register with optional registered status flags.
//
//   Configuration macro: BIP_FLAGS_EN
//     defined   -> Zero/Neg/Ovf are registered status flags
//     undefined -> Zero/Neg/Ovf are tied to 0 and no flag registers exist
//
// Parameters
//   DATA_W     accumulator / ALU / RAM word width (>= 11)
//   RAM_DEPTH  data RAM words; Operand wraps modulo RAM_DEPTH
//
// Ports
//   Clk        clock, all state updates on the rising edge
//   Reset      asynchronous active-high reset (Acc and flags only)
//   SelA[1:0]  accumulator source: 00 RAM, 01 Imm, 10 ALU, 11 hold
//   SelB       ALU B operand: 0 RAM, 1 Imm
//   WrAcc      accumulator write enable
//   Op         ALU operation: 0 add, 1 subtract
//   WrRam      data RAM write enable (writes pre-edge Acc)
//   RdRam      data RAM read enable (RamOut is 0 when low)
//   Operand    11-bit immediate or RAM address
//   Acc        accumulator contents
//   Zero/Neg/Ovf  registered status flags
// -----------------------------------------------------------------------------
module bip_datapath #(
  parameter int DATA_W    = 16,
  parameter int RAM_DEPTH = 2048
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        SelA,
  input  logic              SelB,
  input  logic              WrAcc,
  input  logic              Op,
  input  logic              WrRam,
  input  logic              RdRam,
  input  logic [10:0]       Operand,
  output logic [DATA_W-1:0] Acc,
  output logic              Zero,
  output logic              Neg,
  output logic              Ovf
);

  localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic signed [DATA_W-1:0] mem [RAM_DEPTH];

  logic [ADDR_W-1:0]        ram_addr;
  logic signed [10:0]       operand_s;
  logic signed [DATA_W-1:0] imm;
  logic signed [DATA_W-1:0] ram_out;
  logic signed [DATA_W-1:0] alu_b;
  logic signed [DATA_W-1:0] alu_res;
  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] acc_d;
  logic                     acc_we;

  // Decode, RAM read, ALU and accumulator next-value selection
  always_comb begin
    ram_addr  = ADDR_W'(32'(Operand) % 32'(RAM_DEPTH));
    operand_s = signed'(Operand);
    imm       = DATA_W'(operand_s);
    // Read returns the stored word, so a same-cycle write is seen next cycle
    ram_out   = RdRam ? mem[ram_addr] : '0;
    alu_b     = SelB ? imm : ram_out;
    alu_res   = Op ? (acc_q - alu_b) : (acc_q + alu_b);
    // SelA=11 is hold: it suppresses the write so flags do not update either
    acc_we    = WrAcc && (SelA != 2'b11);
    acc_d     = acc_q;
    if (acc_we) begin
      case (SelA)
        2'b00:   acc_d = ram_out;
        2'b01:   acc_d = imm;
        2'b10:   acc_d = alu_res;
        default: acc_d = acc_q;
      endcase
    end
  end

  // Accumulator register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Data RAM: not reset; writes are blocked while Reset is held
  always_ff @(posedge Clk) begin
    if (WrRam && !Reset) begin
      mem[ram_addr] <= acc_q;
    end
  end

  assign Acc = acc_q;

`ifdef BIP_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  // Signed overflow of a +/- b: subtract is add of ~b, so compare the sign of
  // a with the effective sign of b and then with the sign of the result.
  function automatic logic alu_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] r,
                                   input logic                     sub);
    logic b_sign;
    b_sign  = b[DATA_W-1] ^ sub;
    alu_ovf = (a[DATA_W-1] == b_sign) && (r[DATA_W-1] != a[DATA_W-1]);
  endfunction

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (acc_we) begin
      zero_d = (acc_d == '0);
      neg_d  = acc_d[DATA_W-1];
      ovf_d  = (SelA == 2'b10) && alu_ovf(acc_q, alu_b, alu_res, Op);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Zero = zero_q;
  assign Neg  = neg_q;
  assign Ovf  = ovf_q;
`else
  assign Zero = 1'b0;
  assign Neg  = 1'b0;
  assign Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// -----------------------------------------------------------------------------
// tb_bip_datapath
//   Randomized and directed bench for bip_datapath with a behavioural model
//   (integer arithmetic on word values and an array for the data RAM).
//   Flag expectations follow BIP_FLAGS_EN: tied to 0 when it is undefined.
// -----------------------------------------------------------------------------
module tb_bip_datapath;

  localparam int DATA_W    = 16;
  localparam int RAM_DEPTH = 2048;
`ifdef BIP_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset;
  logic [1:0]        SelA;
  logic              SelB;
  logic              WrAcc;
  logic              Op;
  logic              WrRam;
  logic              RdRam;
  logic [10:0]       Operand;
  logic [DATA_W-1:0] Acc;
  logic              Zero;
  logic              Neg;
  logic              Ovf;

  bip_datapath #(.DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
    .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .Operand(Operand),
    .Acc(Acc), .Zero(Zero), .Neg(Neg), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Model state: word values kept as unsigned 0..65535
  int m_ram [RAM_DEPTH];
  int m_acc;
  bit m_z, m_n, m_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_signed(input int u);
    return (u >= 32768) ? (u - 65536) : u;
  endfunction

  function automatic int imm_of(input logic [10:0] v);
    int s;
    s = v[10] ? (int'(v) - 2048) : int'(v);
    return s & 16'hFFFF;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_acc"},  32'(Acc),  32'(m_acc));
    chk({tag, "_zero"}, 32'(Zero), 32'(FLAGS & m_z));
    chk({tag, "_neg"},  32'(Neg),  32'(FLAGS & m_n));
    chk({tag, "_ovf"},  32'(Ovf),  32'(FLAGS & m_o));
  endtask

  // One instruction cycle: drive, advance model, clock, compare.
  task automatic step(input string tag, input logic [1:0] sa, input logic sb,
                      input logic wa, input logic op, input logic wr,
                      input logic rd, input logic [10:0] opd);
    int addr, ramout, imm, b, sum, nxt;
    bit ovf;
    SelA = sa; SelB = sb; WrAcc = wa; Op = op; WrRam = wr; RdRam = rd;
    Operand = opd;
    addr   = int'(opd) % RAM_DEPTH;
    ramout = rd ? m_ram[addr] : 0;
    imm    = imm_of(opd);
    b      = sb ? imm : ramout;
    sum    = op ? (to_signed(m_acc) - to_signed(b)) : (to_signed(m_acc) + to_signed(b));
    ovf    = (sum > 32767) || (sum < -32768);
    case (sa)
      2'd0:    nxt = ramout;
      2'd1:    nxt = imm;
      2'd2:    nxt = sum & 16'hFFFF;
      default: nxt = m_acc;
    endcase
    if (wr) m_ram[addr] = m_acc;
    if (wa && sa != 2'd3) begin
      m_acc = nxt;
      m_z   = (nxt == 0);
      m_n   = (nxt >= 32768);
      m_o   = (sa == 2'd2) && ovf;
    end
    @(posedge Clk);
    #1;
    chk_state(tag);
  endtask

  initial begin
    Reset = 1'b1; SelA = 2'd3; SelB = 1'b0; WrAcc = 1'b0; Op = 1'b0;
    WrRam = 1'b0; RdRam = 1'b0; Operand = '0;
    m_acc = 0; m_z = 0; m_n = 0; m_o = 0;
    foreach (m_ram[i]) m_ram[i] = 0;
    #1;
    chk_state("reset");
    @(posedge Clk); #1;
    @(posedge Clk); #3;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Clear the whole RAM with Acc=0 so every later read has a known value
    for (int a = 0; a < RAM_DEPTH; a++) step("init", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'(a));

    // Immediate 0x7FF sign-extends to 0xFFFF
    step("imm_neg", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF);
    chk("imm_neg_const", 32'(Acc), 32'h0000_FFFF);
    chk("imm_neg_flagN", 32'(Neg), 32'(FLAGS));

    // Store 5, then Acc - RAM -> 0 with Zero
    step("ld5", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h005);
    step("st5", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h010);
    step("subram", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h010);
    chk("subram_const", 32'(Acc), 32'h0);
    chk("subram_zero", 32'(Zero), 32'(FLAGS));

    // Build 0x8000 from 32 adds of -1024, then -1 wraps to 0x7FFF
    step("clr", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    for (int i = 0; i < 32; i++) step("addneg", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h400);
    step("sub1", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h001);
    chk("sub1_const", 32'(Acc), 32'h7FFF);
    step("add1", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h001);
    chk("add1_const", 32'(Acc), 32'h8000);
    chk("add1_ovf", 32'(Ovf), 32'(FLAGS));
    step("ldclr", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h003);
    chk("ldclr_ovf", 32'(Ovf), 32'h0);

    // Swap: RAM gets old Acc, Acc gets old RAM word
    step("ldAA", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h0AA);
    step("stAA", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h020);
    step("ld55", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h055);
    step("swap", 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h020);
    chk("swap_const", 32'(Acc), 32'h00AA);
    step("rdback", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h020);
    chk("rdback_const", 32'(Acc), 32'h0055);

    // Hold with WrAcc=1
    step("ld42", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h042);
    step("hold", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h7FF);
    chk("hold_const", 32'(Acc), 32'h0042);

    // Randomized instruction stream, mostly on a small address window
    for (int i = 0; i < 600; i++) begin
      logic [10:0] opd;
      opd = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      step("rand", 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), opd);
    end

    // Build 0x1234, park it in RAM[0x55], then reset mid-cycle with a write pending
    step("ld234", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h234);
    for (int i = 0; i < 8; i++) step("add200", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h200);
    chk("pre_rst_const", 32'(Acc), 32'h1234);
    step("st1234", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h055);
    SelA = 2'd1; SelB = 1'b0; WrAcc = 1'b1; Op = 1'b0; WrRam = 1'b1; RdRam = 1'b0;
    Operand = 11'h055;
    #2;
    Reset = 1'b1;
    #1;
    m_acc = 0; m_z = 0; m_n = 0; m_o = 0;
    chk_state("async_rst");
    @(posedge Clk); #1;
    chk_state("rst_held");
    #2;
    Reset = 1'b0;
    step("rst_rd", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h055);
    chk("rst_rd_const", 32'(Acc), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
